// File: rtl/tonegen_poly.sv
// tonegen_poly: CHANNELS independent square-wave tone generators, each with an
//   optional self-silencing note duration, mixed to one pin by a first-order sigma-delta.
// Latency: a write takes effect on the edge that samples it; speaker lags chan_out by 1 cycle.
// Backpressure: none, every cfg_we pulse is accepted in the cycle it is presented.
//
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   cfg_we               single-cycle write strobe
//   cfg_chan             target channel (out-of-range indices are ignored)
//   cfg_divider          half-period minus one, 0 silences the channel
//   cfg_duration         active cycles, 0 plays indefinitely
//   chan_out[CHANNELS]   per-channel square wave (registered)
//   busy[CHANNELS]       channel currently sounding
//   done[CHANNELS]       one-cycle pulse when a duration expires
//   speaker              sigma-delta mixed output (registered)
module tonegen_poly #(
  parameter int CHANNELS  = 4,
  parameter int DIV_WIDTH = 24,
  parameter int DUR_WIDTH = 24,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_chan,
  input  logic [DIV_WIDTH-1:0] cfg_divider,
  input  logic [DUR_WIDTH-1:0] cfg_duration,
  output logic [CHANNELS-1:0]  chan_out,
  output logic [CHANNELS-1:0]  busy,
  output logic [CHANNELS-1:0]  done,
  output logic                 speaker
);

  // Popcount width, and accumulator width: one bit more than needed to hold 2*CHANNELS.
  localparam int SW = $clog2(CHANNELS + 1);
  localparam int TW = $clog2(2 * CHANNELS + 1) + 1;

  logic [DIV_WIDTH-1:0] r_div    [CHANNELS];
  logic [DIV_WIDTH-1:0] r_phase  [CHANNELS];
  logic [DUR_WIDTH-1:0] r_remain [CHANNELS];
  logic [CHANNELS-1:0]  r_busy;
  logic [CHANNELS-1:0]  r_chan_out;
  logic [CHANNELS-1:0]  r_done;
  logic [TW-1:0]        r_acc;
  logic                 r_speaker;

  logic [CHANNELS-1:0]  w_wr;
  logic [SW-1:0]        w_sum;
  logic [TW-1:0]        w_t;

  // Channel select decode. An index >= CHANNELS matches no channel, so such a
  // write is dropped (only reachable when CHANNELS is not a power of two).
  always_comb begin
    w_wr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_wr[i] = cfg_we && (32'(cfg_chan) == i);
    end
  end

  // Per-channel tone and duration state. A write takes priority over the
  // expiry of the same channel, so a rewrite on the expiry cycle restarts the
  // note and suppresses done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_div[i]    <= '0;
        r_phase[i]  <= '0;
        r_remain[i] <= '0;
      end
      r_busy     <= '0;
      r_chan_out <= '0;
      r_done     <= '0;
    end else begin
      r_done <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_wr[i]) begin
          r_div[i]      <= cfg_divider;
          r_phase[i]    <= '0;
          r_remain[i]   <= cfg_duration;
          r_chan_out[i] <= 1'b0;
          r_busy[i]     <= (cfg_divider != '0);
        end else if (r_busy[i]) begin
          if (r_remain[i] == DUR_WIDTH'(1)) begin
            // Last active cycle: silence and flag completion.
            r_busy[i]     <= 1'b0;
            r_chan_out[i] <= 1'b0;
            r_remain[i]   <= '0;
            r_phase[i]    <= '0;
            r_done[i]     <= 1'b1;
          end else begin
            if (r_remain[i] != '0) begin
              r_remain[i] <= r_remain[i] - DUR_WIDTH'(1);
            end
            // phase counts 0..div, so it can never wrap.
            if (r_phase[i] == r_div[i]) begin
              r_chan_out[i] <= ~r_chan_out[i];
              r_phase[i]    <= '0;
            end else begin
              r_phase[i] <= r_phase[i] + DIV_WIDTH'(1);
            end
          end
        end
      end
    end
  end

  // Mixer: number of channels currently high, added into the accumulator.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_sum = w_sum + SW'(r_chan_out[i]);
    end
    w_t = r_acc + TW'(w_sum);
  end

  // First-order sigma-delta: emit a 1 whenever the accumulator crosses
  // CHANNELS, giving a long-run density of sum/CHANNELS.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc     <= '0;
      r_speaker <= 1'b0;
    end else if (w_t >= TW'(CHANNELS)) begin
      r_acc     <= w_t - TW'(CHANNELS);
      r_speaker <= 1'b1;
    end else begin
      r_acc     <= w_t;
      r_speaker <= 1'b0;
    end
  end

  assign chan_out = r_chan_out;
  assign busy     = r_busy;
  assign done     = r_done;
  assign speaker  = r_speaker;

endmodule

// File: tb/tb_tonegen_poly.sv
// tb_tonegen_poly: directed checks of tonegen_poly (4 channels) plus a 3-channel
//   instance used for the out-of-range channel write.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_tonegen_poly;

  logic        clk;
  logic        resetn;
  logic        cfg_we;
  logic        cfg_we3;
  logic [1:0]  cfg_chan;
  logic [23:0] cfg_divider;
  logic [23:0] cfg_duration;
  logic [3:0]  chan_out;
  logic [3:0]  busy;
  logic [3:0]  done;
  logic        speaker;
  logic [2:0]  chan_out3;
  logic [2:0]  busy3;
  logic [2:0]  done3;
  logic        speaker3;

  int n_checks = 0;
  int n_fail   = 0;

  tonegen_poly #(.CHANNELS(4), .DIV_WIDTH(24), .DUR_WIDTH(24)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cfg_we       (cfg_we),
    .cfg_chan     (cfg_chan),
    .cfg_divider  (cfg_divider),
    .cfg_duration (cfg_duration),
    .chan_out     (chan_out),
    .busy         (busy),
    .done         (done),
    .speaker      (speaker)
  );

  tonegen_poly #(.CHANNELS(3), .DIV_WIDTH(24), .DUR_WIDTH(24)) dut3 (
    .clk          (clk),
    .resetn       (resetn),
    .cfg_we       (cfg_we3),
    .cfg_chan     (cfg_chan),
    .cfg_divider  (cfg_divider),
    .cfg_duration (cfg_duration),
    .chan_out     (chan_out3),
    .busy         (busy3),
    .done         (done3),
    .speaker      (speaker3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a write for one cycle; returns just after the edge that sampled it.
  task automatic wr(input int ch, input int dv, input int du);
    cfg_chan     = 2'(ch);
    cfg_divider  = 24'(dv);
    cfg_duration = 24'(du);
    cfg_we       = 1'b1;
    tick();
    cfg_we       = 1'b0;
  endtask

  initial begin
    int cnt_busy, cnt_done, cnt_tog, cnt_one, acc_or;
    logic prev;

    resetn = 1'b0; cfg_we = 1'b0; cfg_we3 = 1'b0;
    cfg_chan = '0; cfg_divider = '0; cfg_duration = '0;
    repeat (3) tick();
    check("reset_outs", {20'd0, chan_out, busy, done}, 32'd0);
    check("reset_spk", {31'd0, speaker}, 32'd0);
    resetn = 1'b1;
    tick();

    // Ch0 div=3 dur=0: period 8, continuous, never done.
    wr(0, 3, 0);
    check("t1_start", {30'd0, busy[0], chan_out[0]}, 32'b10);
    cnt_busy = 0; cnt_done = 0; cnt_tog = 0; prev = chan_out[0];
    for (int j = 1; j <= 1000; j++) begin
      tick();
      if (j <= 16) check($sformatf("t1_chan_j%0d", j), {31'd0, chan_out[0]}, 32'((j / 4) % 2));
      if (busy[0]) cnt_busy++;
      if (done != 4'd0) cnt_done++;
      if (chan_out[0] != prev) cnt_tog++;
      prev = chan_out[0];
    end
    check("t1_busy_cycles", 32'(cnt_busy), 32'd1000);
    check("t1_done_cnt", 32'(cnt_done), 32'd0);
    check("t1_toggles", 32'(cnt_tog), 32'd250);
    wr(0, 0, 0);
    check("t1_silence", {28'd0, busy}, 32'd0);

    // Ch1 div=1 dur=10: busy 10 cycles, done at k+10.
    wr(1, 1, 10);
    check("t2_j0", {29'd0, busy[1], done[1], chan_out[1]}, 32'b100);
    for (int j = 1; j <= 13; j++) begin
      tick();
      check($sformatf("t2_j%0d", j), {29'd0, busy[1], done[1], chan_out[1]},
            {29'd0, (j <= 9), (j == 10), (j <= 9) ? 1'((j / 2) % 2) : 1'b0});
    end

    // Ch2 div=5 then rewritten with div=0: silenced at once, no done.
    wr(2, 5, 0);
    repeat (20) tick();
    check("t3_playing", {31'd0, chan_out[2]}, 32'd1);
    wr(2, 0, 0);
    check("t3_silenced", {29'd0, busy[2], chan_out[2], done[2]}, 32'd0);
    cnt_done = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (done != 4'd0) cnt_done++;
    end
    check("t3_no_done", 32'(cnt_done), 32'd0);

    // Two of four channels high: speaker alternates, density 1/2.
    wr(0, 1000, 0);
    wr(1, 1000, 0);
    repeat (1003) tick();
    check("t4_both_high", {28'd0, chan_out}, 32'b0011);
    prev = speaker; cnt_one = 0; cnt_tog = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (speaker) cnt_one++;
      if (speaker != prev) cnt_tog++;
      prev = speaker;
    end
    check("t4_spk_ones", 32'(cnt_one), 32'd4);
    check("t4_spk_alt", 32'(cnt_tog), 32'd8);

    // All four high: speaker constantly 1.
    wr(0, 200, 0); wr(1, 200, 0); wr(2, 200, 0); wr(3, 200, 0);
    repeat (205) tick();
    check("t5_all_high", {28'd0, chan_out}, 32'hF);
    cnt_one = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (speaker) cnt_one++;
    end
    check("t5_spk_ones", 32'(cnt_one), 32'd20);

    // Ch3 dur=5, rewritten on the expiry edge: restart, no done.
    wr(3, 2, 5);
    repeat (4) tick();
    wr(3, 2, 5);
    check("t6_collide", {24'd0, busy[3], done[3], chan_out[3], 1'b0, done}, {24'd0, 4'b1000, 4'd0});
    for (int j = 1; j <= 6; j++) begin
      tick();
      check($sformatf("t6_j%0d", j), {29'd0, busy[3], done[3], chan_out[3]},
            {29'd0, (j <= 4), (j == 5), (j >= 3 && j <= 4)});
    end
    check("t6_others_busy", {29'd0, busy[2:0]}, 32'b111);

    // Out-of-range channel on the 3-channel instance is ignored.
    cfg_chan = 2'd3; cfg_divider = 24'd2; cfg_duration = 24'd0; cfg_we3 = 1'b1;
    tick();
    cfg_we3 = 1'b0;
    repeat (5) tick();
    check("t7_oor_ignored", {26'd0, busy3, chan_out3}, 32'd0);
    cfg_chan = 2'd2; cfg_we3 = 1'b1;
    tick();
    cfg_we3 = 1'b0;
    check("t7_inrange", {29'd0, busy3}, 32'b100);

    // Asynchronous reset mid-tone.
    wr(0, 3, 0); wr(1, 3, 0); wr(2, 3, 0); wr(3, 3, 0);
    repeat (10) tick();
    check("t8_pre_busy", {28'd0, busy}, 32'hF);
    resetn = 1'b0;
    #2;
    check("t8_async_outs", {20'd0, chan_out, busy, done}, 32'd0);
    check("t8_async_spk", {31'd0, speaker}, 32'd0);
    tick();
    resetn = 1'b1;
    acc_or = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      acc_or = acc_or | int'({chan_out, busy, done, speaker});
    end
    check("t8_idle_after", 32'(acc_or), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
